// File: rtl/alu_issue_unit.sv
// alu_issue_unit: execute-stage front end for a 16-bit combinational ALU.
// Two stages: E (issue register, ID/EX) feeds the ALU, R (result register,
// EX/MEM) holds the registered result for downstream.
// Optional build macro: ALU_ISSUE_FWD_EN (bypass from R into E operands).
// Without it, decode is held off until any producer of a used source drains.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready; once raised, res_valid and res_data/res_rd
// stay stable until the transfer completes.
module alu_issue_unit #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [1:0]        dec_func,
  input  logic              dec_use_imm,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic [DATA_W-1:0] dec_rs1_val,
  input  logic [DATA_W-1:0] dec_rs2_val,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_W-1:0]  res_rd
);

  localparam logic [1:0] FUNC_NOP = 2'b11;

  // E stage
  logic              e_valid;
  logic [1:0]        e_op;
  logic [REG_W-1:0]  e_rd;
  logic [DATA_W-1:0] e_a;
  logic [DATA_W-1:0] e_b;
`ifdef ALU_ISSUE_FWD_EN
  logic [REG_W-1:0]  e_rs1;
  logic [REG_W-1:0]  e_rs2;
  logic              e_b_imm;
`endif

  // R stage
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [REG_W-1:0]  r_rd;

  logic              adv_r;
  logic              adv_e;
  logic              e_fire;
  logic              accept;
  logic              hazard;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // Pipeline advance conditions; a flushed E entry never reaches R
  always_comb begin
    adv_r  = !r_valid || res_ready;
    adv_e  = e_valid && adv_r;
    e_fire = adv_e && !flush;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Effective operands: R result bypasses stale captured sources; no stalls
  always_comb begin
    op_a   = e_a;
    op_b   = e_b;
    hazard = 1'b0;
    if (e_valid && r_valid && (r_rd != '0)) begin
      if (r_rd == e_rs1) op_a = r_data;
      if (!e_b_imm && (r_rd == e_rs2)) op_b = r_data;
    end
  end
`else
  // No bypass: stall decode while a used nonzero source is still in flight
  always_comb begin
    logic rs1_busy;
    logic rs2_busy;
    op_a     = e_a;
    op_b     = e_b;
    rs1_busy = (dec_rs1 != '0) &&
               ((e_valid && (dec_rs1 == e_rd)) || (r_valid && (dec_rs1 == r_rd)));
    rs2_busy = (dec_rs2 != '0) && !dec_use_imm &&
               ((e_valid && (dec_rs2 == e_rd)) || (r_valid && (dec_rs2 == r_rd)));
    hazard   = dec_valid && (rs1_busy || rs2_busy);
  end
`endif

  // Decode handshake and ALU drive; NOP presents AND to the ALU
  always_comb begin
    dec_ready = !flush && (!e_valid || adv_r) && !hazard;
    accept    = dec_valid && dec_ready;
    alu_a     = op_a;
    alu_b     = op_b;
    alu_op    = (e_op == FUNC_NOP) ? 2'b00 : e_op;
    res_valid = r_valid;
    res_data  = r_data;
    res_rd    = r_rd;
  end

  // Issue register: load on accept; otherwise freeze the effective operands
  // so the ALU inputs hold their last values once E drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_rd    <= '0;
      e_a     <= '0;
      e_b     <= '0;
`ifdef ALU_ISSUE_FWD_EN
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_b_imm <= 1'b0;
`endif
    end else if (accept) begin
      e_valid <= 1'b1;
      e_op    <= dec_func;
      e_rd    <= (dec_func == FUNC_NOP) ? '0 : dec_rd;
      e_a     <= dec_rs1_val;
      e_b     <= dec_use_imm ? dec_imm : dec_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
      e_rs1   <= dec_rs1;
      e_rs2   <= dec_rs2;
      e_b_imm <= dec_use_imm;
`endif
    end else begin
      if (flush || adv_e) e_valid <= 1'b0;
      e_a <= op_a;
      e_b <= op_b;
    end
  end

  // Result register: capture ALU output on advance, drop on handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rd    <= '0;
    end else if (e_fire) begin
      r_valid <= 1'b1;
      r_data  <= (e_op == FUNC_NOP) ? '0 : alu_result;
      r_rd    <= e_rd;
    end else if (res_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: directed vectors, scoreboard queue, monitor.
module tb_alu_issue_unit;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int EW = DW + RW;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic          dec_ready;
  logic [1:0]    dec_func;
  logic          dec_use_imm;
  logic [RW-1:0] dec_rs1;
  logic [RW-1:0] dec_rs2;
  logic [RW-1:0] dec_rd;
  logic [DW-1:0] dec_rs1_val;
  logic [DW-1:0] dec_rs2_val;
  logic [DW-1:0] dec_imm;
  logic          flush;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int w;

  alu_issue_unit #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_func(dec_func),
    .dec_use_imm(dec_use_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .dec_imm(dec_imm), .flush(flush), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd)
  );

  // Clock
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a + alu_b;
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction, push its expected result when it is accepted
  task automatic send(input logic [1:0] f, input logic use_imm,
                      input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                      input logic [RW-1:0] rd, input logic [DW-1:0] v1,
                      input logic [DW-1:0] v2, input logic [DW-1:0] imm,
                      input logic [DW-1:0] exp_data, output int waits);
    logic done;
    logic [RW-1:0] erd;
    dec_valid = 1'b1; dec_func = f; dec_use_imm = use_imm;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_rs1_val = v1; dec_rs2_val = v2; dec_imm = imm;
    erd = (f == 2'b11) ? '0 : rd;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (dec_ready) begin
        exp_q.push_back({erd, exp_data});
        done = 1'b1;
      end else begin
        waits++;
        if (waits >= 20) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout actual=no_accept expected=accept rd=%0d", rd);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    dec_valid = 1'b0;
  endtask

  // Monitor: compare every completed result handshake against the queue head
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h expected=none", {res_rd, res_data});
        end else begin
          e = exp_q.pop_front();
          chk("result", {13'd0, res_rd, res_data}, {13'd0, e});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    reset = 1'b0; flush = 1'b0; res_ready = 1'b1;
    dec_valid = 1'b1; dec_func = 2'b01; dec_use_imm = 1'b0;
    dec_rs1 = 3'd6; dec_rs2 = 3'd7; dec_rd = 3'd1;
    dec_rs1_val = 16'd9; dec_rs2_val = 16'd9; dec_imm = '0;

    // Reset held two cycles with an offer pending
    repeat (2) begin
      @(negedge clk);
      chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1; dec_valid = 1'b0;
    @(negedge clk);
    chk("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_res_rd", {29'd0, res_rd}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    @(posedge clk); #1;

    // Basic arithmetic
    send(2'b01, 1'b0, 3'd6, 3'd7, 3'd1, 16'd3, 16'd2, 16'd0, 16'd5, w);
    chk("add_alu_a", {16'd0, alu_a}, 32'd3);
    chk("add_alu_b", {16'd0, alu_b}, 32'd2);
    chk("add_alu_op", {30'd0, alu_op}, 32'd1);
    cyc(1);
    chk("latency_valid", {31'd0, res_valid}, 32'd1);
    chk("latency_data", {16'd0, res_data}, 32'd5);
    send(2'b10, 1'b0, 3'd6, 3'd7, 3'd2, 16'd30, 16'd20, 16'd0, 16'd10, w);
    send(2'b00, 1'b0, 3'd6, 3'd7, 3'd3, 16'd3, 16'd2, 16'd0, 16'd2, w);
    chk("b2b_waits", w, 32'd0);
    send(2'b01, 1'b1, 3'd6, 3'd0, 3'd4, 16'd15, 16'd0, 16'hFFF6, 16'd5, w);
    send(2'b10, 1'b0, 3'd6, 3'd7, 3'd5, 16'hFFEC, 16'h0019, 16'd0, 16'hFFD3, w);
    send(2'b11, 1'b0, 3'd0, 3'd0, 3'd3, 16'd7, 16'd7, 16'd0, 16'd0, w);
    chk("nop_alu_op", {30'd0, alu_op}, 32'd0);
    cyc(3);

    // Dependent back-to-back pair through r1
    send(2'b01, 1'b1, 3'd6, 3'd0, 3'd1, 16'h7FFF, 16'd0, 16'd1, 16'h8000, w);
`ifdef ALU_ISSUE_FWD_EN
    send(2'b10, 1'b1, 3'd1, 3'd0, 3'd2, 16'h1234, 16'd0, 16'd1, 16'h7FFF, w);
    chk("fwd_waits", w, 32'd0);
`else
    send(2'b10, 1'b1, 3'd1, 3'd0, 3'd2, 16'h8000, 16'd0, 16'd1, 16'h7FFF, w);
    chk("stall_waits", w, 32'd2);
`endif
    cyc(3);

    // Backpressure
    res_ready = 1'b0;
    send(2'b01, 1'b0, 3'd6, 3'd7, 3'd3, 16'd10, 16'd1, 16'd0, 16'd11, w);
    send(2'b10, 1'b0, 3'd6, 3'd7, 3'd4, 16'd10, 16'd1, 16'd0, 16'd9, w);
    dec_valid = 1'b1; dec_func = 2'b00; dec_use_imm = 1'b0;
    dec_rs1 = 3'd6; dec_rs2 = 3'd7; dec_rd = 3'd5;
    dec_rs1_val = 16'd6; dec_rs2_val = 16'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_dec_ready", {31'd0, dec_ready}, 32'd0);
      chk("bp_res_data", {16'd0, res_data}, 32'd11);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    send(2'b00, 1'b0, 3'd6, 3'd7, 3'd5, 16'd6, 16'd3, 16'd0, 16'd2, w);
    chk("bp_release_waits", w, 32'd0);
    chk("bp_second", {15'd0, res_valid, res_data}, {15'd0, 1'b1, 16'd9});
    cyc(1);
    chk("bp_third", {15'd0, res_valid, res_data}, {15'd0, 1'b1, 16'd2});
    cyc(2);

    // Flush of E while R is stalled
    res_ready = 1'b0;
    send(2'b01, 1'b0, 3'd6, 3'd7, 3'd1, 16'd4, 16'd4, 16'd0, 16'd8, w);
    send(2'b10, 1'b0, 3'd6, 3'd7, 3'd2, 16'd4, 16'd1, 16'd0, 16'd3, w);
    void'(exp_q.pop_back());
    flush = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("flush_dec_ready", {31'd0, dec_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_empty_now", {31'd0, res_valid}, 32'd0);
    cyc(2);
    chk("flush_empty_later", {31'd0, res_valid}, 32'd0);

    // rd=0 producer then rs1=0 consumer
    send(2'b01, 1'b0, 3'd6, 3'd7, 3'd0, 16'd1, 16'd1, 16'd0, 16'd2, w);
    send(2'b01, 1'b0, 3'd0, 3'd7, 3'd5, 16'd0, 16'd5, 16'd0, 16'd5, w);
    chk("zero_reg_waits", w, 32'd0);
    cyc(3);

    // Reset during a stall discards the pending result
    res_ready = 1'b0;
    send(2'b01, 1'b0, 3'd6, 3'd7, 3'd1, 16'd2, 16'd2, 16'd0, 16'd4, w);
    cyc(2);
    void'(exp_q.pop_back());
    reset = 1'b0;
    cyc(1);
    reset = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("reset_stall_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;

    cyc(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Execute-stage front end that drives the 16-bit combinational ALU (ports A, B, ALUop) and captures its Output.
- Accepts decoded ALU instructions from decode over a valid/ready handshake and holds them in an issue register (ID/EX).
- Drives the ALU operands, with optional bypass from the result register, and presents registered results downstream over a second valid/ready handshake (EX/MEM).

Parameters:
- DATA_W, 16, operand/result width; must match ALU width.
- REG_W, 3, register index width; index 0 is hardwired zero.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- dec_valid  input  1  decode offers instruction
- dec_ready  output  1  unit accepts instruction this cycle
- dec_func  input  2  00 AND, 01 ADD, 10 SUB, 11 NOP
- dec_use_imm  input  1  B operand = dec_imm instead of rs2 value
- dec_rs1, dec_rs2, dec_rd  input  REG_W  source/destination indices
- dec_rs1_val, dec_rs2_val  input  DATA_W  register-file read values (file is write-through)
- dec_imm  input  DATA_W  immediate, already extended by decode
- flush  input  1  kill instruction in issue register
- alu_a, alu_b  output  DATA_W  to ALU A, B
- alu_op  output  2  to ALU ALUop: 00 AND, 01 ADD, 10 SUB
- alu_result  input  DATA_W  from ALU Output
- res_valid  output  1  result register holds a result
- res_ready  input  1  downstream consumes result; writes the register file on the handshake cycle
- res_data  output  DATA_W  registered result
- res_rd  output  REG_W  destination of result

Behaviour:
- Two stages. E = issue register: e_valid, op, rd, rs1/rs2, a_val, b_val, b_is_imm. R = result register: r_valid, data, rd.
- Reset (reset==0 at clk edge) clears e_valid and r_valid and zeroes all data/index fields. Outputs after reset: dec_ready=1, res_valid=0, res_data=0, res_rd=0, alu_a=0, alu_b=0, alu_op=00.
- adv_r = !r_valid || res_ready.
- adv_e = e_valid && adv_r.
- dec_ready = !flush && (!e_valid || adv_r) && !hazard. hazard is 0 when bypass is enabled (see Optional Feature).
- Accept (dec_valid && dec_ready): E is loaded with decoded fields. a_val = dec_rs1_val. b_val = dec_use_imm ? dec_imm : dec_rs2_val.
- NOP (func 11) has rd forced to 0. It flows through and produces res_data=0. alu_op is driven 00 for it.
- alu_op and operands are driven combinationally from E and are valid whenever e_valid=1. When e_valid=0 the last values are held.
- adv_e: R is loaded with alu_result and E.rd; r_valid=1.
- R handshake without adv_e: r_valid=0.
- E empties when adv_e occurs without an accept in the same cycle.
- Accept and adv_e in the same cycle is legal: back-to-back throughput is one instruction per cycle.
- Latency: accept at edge N, result visible on res_* after edge N+1, provided res_ready has been high.
- Backpressure: res_valid=1 with res_ready=0 holds R and E unchanged and deasserts dec_ready while E is full. res_data is stable while stalled.
- flush: at the edge, e_valid=0 and no accept occurs. R is unaffected, and a pending R handshake still completes.
- Arithmetic: two's complement, wraps modulo 2^DATA_W. No flags.
- Reset mid-stall discards both stages; no result is emitted.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: for each E source, if r_valid && R.rd!=0 && R.rd==E.rs, R.data replaces the captured value. This applies to rs1 always and to rs2 only when !b_is_imm. hazard=0.
- Undefined: no bypass. hazard=1 when dec_valid and any used source (rs1; rs2 only if !dec_use_imm), being nonzero, equals E.rd with e_valid, or equals R.rd with r_valid. Decode then stalls until the producer has drained through the R handshake.

Test Plan:
- Reset held low 2 cycles with dec_valid=1: no accept, res_valid=0, dec_ready=1 after release.
- ADD rd=1 (3+2), res_ready=1: res_data=5 one edge after accept. SUB 30-20 -> 10. AND 3&2 -> 2. 15+(-10) -> 5. -20-25 -> -45 (0xFFD3).
- Back-to-back ADD r1=0x7FFF+1, then SUB r2=r1-1 via rs1=1. FWD_EN: r2 result 0x7FFF next cycle, and the first result wraps to 0x8000. Without the macro: dec_ready low until the r1 handshake, then the correct r2 result arrives.
- res_ready=0 for 4 cycles with two instructions issued: third offer sees dec_ready=0; res_data holds the first result. On release, results emerge in order, one per cycle.
- flush asserted while E holds SUB and R is stalled: SUB never appears; R result still delivered.
- rd=0 producer followed by rs1=0 consumer: no bypass, no stall; operand taken from dec_rs1_val.
